// File: rtl/alu_defs.sv
// alu_defs: widths, ALU encodings and the ID/EX bundle shared by
// the operand stage, its hazard/forward unit and its interface.
package alu_defs;
  localparam int XLEN   = 32;
  localparam int REG_AW = 5;
  localparam int CTL_W  = 3;

  typedef enum logic [CTL_W-1:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b101
  } alu_op_e;

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic              alu_src;
    logic [CTL_W-1:0]  alu_control;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
  } id_ex_t;

  // empty slot: nothing valid, ALU idles on ADD of zeros
  localparam id_ex_t ID_EX_BUBBLE = '{
    valid:       1'b0,
    pc:          '0,
    rs1_data:    '0,
    rs2_data:    '0,
    imm:         '0,
    rs1:         '0,
    rs2:         '0,
    rd:          '0,
    alu_src:     1'b0,
    alu_control: ALU_ADD,
    reg_write:   1'b0,
    mem_read:    1'b0,
    mem_write:   1'b0
  };

  function automatic logic rd_hit(
    input logic              we,
    input logic [REG_AW-1:0] rd,
    input logic [REG_AW-1:0] rs
  );
    return we & (rd != '0) & (rd == rs);
  endfunction
endpackage

// File: rtl/alu_operand_stage_if.sv
// alu_operand_stage_if: decode inputs, downstream bypass/control
// inputs and EX-side outputs of the ID/EX operand stage.
interface alu_operand_stage_if;
  import alu_defs::*;

  logic              id_valid;
  logic [XLEN-1:0]   id_pc;
  logic [XLEN-1:0]   id_rs1_data;
  logic [XLEN-1:0]   id_rs2_data;
  logic [XLEN-1:0]   id_imm;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic              id_alu_src;
  logic [CTL_W-1:0]  id_alu_control;
  logic              id_reg_write;
  logic              id_mem_read;
  logic              id_mem_write;
  logic              ex_hold;
  logic              ex_flush;
  logic [REG_AW-1:0] mem_rd;
  logic              mem_reg_write;
  logic [XLEN-1:0]   mem_result;
  logic [REG_AW-1:0] wb_rd;
  logic              wb_reg_write;
  logic [XLEN-1:0]   wb_result;

  logic              stall_req;
  logic              ex_valid;
  logic [XLEN-1:0]   ex_pc;
  logic [XLEN-1:0]   src_a;
  logic [XLEN-1:0]   src_b;
  logic [CTL_W-1:0]  alu_control;
  logic [XLEN-1:0]   ex_store_data;
  logic [REG_AW-1:0] ex_rd;
  logic              ex_reg_write;
  logic              ex_mem_read;
  logic              ex_mem_write;

  modport master (
    output id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
    output id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
    output id_alu_src, id_alu_control,
    output id_reg_write, id_mem_read, id_mem_write,
    output ex_hold, ex_flush,
    output mem_rd, mem_reg_write, mem_result,
    output wb_rd, wb_reg_write, wb_result,
    input  stall_req, ex_valid, ex_pc, src_a, src_b,
    input  alu_control, ex_store_data, ex_rd,
    input  ex_reg_write, ex_mem_read, ex_mem_write
  );

  modport slave (
    input  id_valid, id_pc, id_rs1_data, id_rs2_data, id_imm,
    input  id_rs1, id_rs2, id_rd, id_use_rs1, id_use_rs2,
    input  id_alu_src, id_alu_control,
    input  id_reg_write, id_mem_read, id_mem_write,
    input  ex_hold, ex_flush,
    input  mem_rd, mem_reg_write, mem_result,
    input  wb_rd, wb_reg_write, wb_result,
    output stall_req, ex_valid, ex_pc, src_a, src_b,
    output alu_control, ex_store_data, ex_rd,
    output ex_reg_write, ex_mem_read, ex_mem_write
  );
endinterface

// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: load-use/RAW stall decision and EX operand selects.
// ALU_OPERAND_FWD_EN enables MEM/WB bypass; otherwise RAW stalls.
module hazard_fwd_unit
  import alu_defs::*;
(
  input  logic              id_valid,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              ex_valid,
  input  logic              ex_mem_read,
  input  logic              ex_reg_write,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic [REG_AW-1:0] ex_rs1,
  input  logic [REG_AW-1:0] ex_rs2,
  input  logic [XLEN-1:0]   ex_rs1_data,
  input  logic [XLEN-1:0]   ex_rs2_data,
  input  logic              ex_hold,
  input  logic [REG_AW-1:0] mem_rd,
  input  logic              mem_reg_write,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic              wb_reg_write,
  input  logic [XLEN-1:0]   wb_result,
  output logic              stall_req,
  output logic              bubble,
  output logic [XLEN-1:0]   fwd_a,
  output logic [XLEN-1:0]   fwd_b
);
  logic load_use;
  logic raw;

  assign load_use = ex_valid & ex_mem_read & id_valid &
    ((id_use_rs1 & rd_hit(1'b1, ex_rd, id_rs1)) |
     (id_use_rs2 & rd_hit(1'b1, ex_rd, id_rs2)));

`ifdef ALU_OPERAND_FWD_EN
  logic unused_ok;
  assign unused_ok = ex_reg_write;
  assign raw = 1'b0;

  // MEM is younger than WB, so it wins
  assign fwd_a =
    rd_hit(mem_reg_write, mem_rd, ex_rs1) ? mem_result :
    rd_hit(wb_reg_write, wb_rd, ex_rs1)   ? wb_result  :
    ex_rs1_data;
  assign fwd_b =
    rd_hit(mem_reg_write, mem_rd, ex_rs2) ? mem_result :
    rd_hit(wb_reg_write, wb_rd, ex_rs2)   ? wb_result  :
    ex_rs2_data;
`else
  logic busy1;
  logic busy2;
  logic unused_ok;

  // wait until the producer has retired through the write-first RF
  assign busy1 =
    rd_hit(ex_valid & ex_reg_write, ex_rd, id_rs1) |
    rd_hit(mem_reg_write, mem_rd, id_rs1) |
    rd_hit(wb_reg_write, wb_rd, id_rs1);
  assign busy2 =
    rd_hit(ex_valid & ex_reg_write, ex_rd, id_rs2) |
    rd_hit(mem_reg_write, mem_rd, id_rs2) |
    rd_hit(wb_reg_write, wb_rd, id_rs2);
  assign raw = id_valid &
    ((id_use_rs1 & busy1) | (id_use_rs2 & busy2));

  assign fwd_a = ex_rs1_data;
  assign fwd_b = ex_rs2_data;
  assign unused_ok = ^{mem_result, wb_result, ex_rs1, ex_rs2};
`endif

  assign bubble    = load_use | raw;
  assign stall_req = bubble | ex_hold;
endmodule

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: ID/EX register feeding the ALU, with hazard
// bubbles, hold/flush and optional bypass (ALU_OPERAND_FWD_EN).
module alu_operand_stage
  import alu_defs::*;
(
  input logic                clk,
  input logic                rst_n,
  alu_operand_stage_if.slave bus
);
  id_ex_t          q;
  id_ex_t          d;
  id_ex_t          cap;
  logic            bubble;
  logic [XLEN-1:0] fwd_a;
  logic [XLEN-1:0] fwd_b;

  hazard_fwd_unit u_hzd (
    .id_valid      (bus.id_valid),
    .id_use_rs1    (bus.id_use_rs1),
    .id_use_rs2    (bus.id_use_rs2),
    .id_rs1        (bus.id_rs1),
    .id_rs2        (bus.id_rs2),
    .ex_valid      (q.valid),
    .ex_mem_read   (q.mem_read),
    .ex_reg_write  (q.reg_write & q.valid),
    .ex_rd         (q.rd),
    .ex_rs1        (q.rs1),
    .ex_rs2        (q.rs2),
    .ex_rs1_data   (q.rs1_data),
    .ex_rs2_data   (q.rs2_data),
    .ex_hold       (bus.ex_hold),
    .mem_rd        (bus.mem_rd),
    .mem_reg_write (bus.mem_reg_write),
    .mem_result    (bus.mem_result),
    .wb_rd         (bus.wb_rd),
    .wb_reg_write  (bus.wb_reg_write),
    .wb_result     (bus.wb_result),
    .stall_req     (bus.stall_req),
    .bubble        (bubble),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b)
  );

  assign cap = '{
    valid:       bus.id_valid,
    pc:          bus.id_pc,
    rs1_data:    bus.id_rs1_data,
    rs2_data:    bus.id_rs2_data,
    imm:         bus.id_imm,
    rs1:         bus.id_rs1,
    rs2:         bus.id_rs2,
    rd:          bus.id_rd,
    alu_src:     bus.id_alu_src,
    alu_control: bus.id_alu_control,
    reg_write:   bus.id_reg_write & bus.id_valid,
    mem_read:    bus.id_mem_read & bus.id_valid,
    mem_write:   bus.id_mem_write & bus.id_valid
  };

  always_comb begin
    d = q;
    if (bus.ex_flush)
      d = ID_EX_BUBBLE;
    else if (bus.ex_hold)
      d = q;
    else if (bubble)
      d = ID_EX_BUBBLE;
    else
      d = cap;
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      q <= ID_EX_BUBBLE;
    else
      q <= d;
  end

  assign bus.ex_valid      = q.valid;
  assign bus.ex_pc         = q.pc;
  assign bus.src_a         = fwd_a;
  assign bus.src_b         = q.alu_src ? q.imm : fwd_b;
  assign bus.alu_control   = q.alu_control;
  assign bus.ex_store_data = fwd_b;
  assign bus.ex_rd         = q.rd;
  assign bus.ex_reg_write  = q.reg_write & q.valid;
  assign bus.ex_mem_read   = q.mem_read & q.valid;
  assign bus.ex_mem_write  = q.mem_write & q.valid;
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed scenarios and a randomized run checked
// against a behavioural ID/EX model; follows ALU_OPERAND_FWD_EN.
module tb_alu_operand_stage;
  import alu_defs::*;

`ifdef ALU_OPERAND_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;

  alu_operand_stage_if bus();

  alu_operand_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          v;
    logic [31:0] pc, a, b, imm;
    logic [4:0]  rs1, rs2, rd;
    bit          isrc;
    logic [2:0]  ctl;
    bit          rw, mr, mw;
  } ex_rec_t;

  ex_rec_t m;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    bus.id_valid = 0; bus.id_pc = 0;
    bus.id_rs1_data = 0; bus.id_rs2_data = 0; bus.id_imm = 0;
    bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0;
    bus.id_use_rs1 = 0; bus.id_use_rs2 = 0;
    bus.id_alu_src = 0; bus.id_alu_control = 0;
    bus.id_reg_write = 0; bus.id_mem_read = 0; bus.id_mem_write = 0;
    bus.ex_hold = 0; bus.ex_flush = 0;
    bus.mem_rd = 0; bus.mem_reg_write = 0; bus.mem_result = 0;
    bus.wb_rd = 0; bus.wb_reg_write = 0; bus.wb_result = 0;
  endtask

  // ---------------- reference model ----------------
  function automatic bit writes(bit we, logic [4:0] rd, logic [4:0] rs);
    return we && rd != 0 && rd == rs;
  endfunction

  function automatic logic [31:0] model_opnd(logic [4:0] r,
                                             logic [31:0] stored);
    if (FWD && writes(bus.mem_reg_write, bus.mem_rd, r))
      return bus.mem_result;
    if (FWD && writes(bus.wb_reg_write, bus.wb_rd, r))
      return bus.wb_result;
    return stored;
  endfunction

  function automatic bit model_busy(logic [4:0] rs);
    return writes(m.v && m.rw, m.rd, rs) ||
           writes(bus.mem_reg_write, bus.mem_rd, rs) ||
           writes(bus.wb_reg_write, bus.wb_rd, rs);
  endfunction

  function automatic bit model_bubble();
    bit lu, raw;
    lu = m.v && m.mr && bus.id_valid &&
         ((bus.id_use_rs1 && writes(1, m.rd, bus.id_rs1)) ||
          (bus.id_use_rs2 && writes(1, m.rd, bus.id_rs2)));
    raw = !FWD && bus.id_valid &&
          ((bus.id_use_rs1 && model_busy(bus.id_rs1)) ||
           (bus.id_use_rs2 && model_busy(bus.id_rs2)));
    return lu || raw;
  endfunction

  function automatic ex_rec_t empty_rec();
    ex_rec_t r;
    r.v = 0; r.pc = 0; r.a = 0; r.b = 0; r.imm = 0;
    r.rs1 = 0; r.rs2 = 0; r.rd = 0; r.isrc = 0; r.ctl = 0;
    r.rw = 0; r.mr = 0; r.mw = 0;
    return r;
  endfunction

  // ---------------- directed tests ----------------
  task automatic test_reset();
    rst_n = 0;
    clear_in();
    bus.id_valid = 1; bus.id_rd = 3; bus.id_reg_write = 1;
    bus.id_alu_control = 3'b011; bus.id_rs1_data = 9; bus.id_pc = 32'h100;
    tick(); tick();
    @(negedge clk);
    tests++;
    if (bus.ex_valid !== 1'b0) begin
      fails++; $display("FAIL rst_ex_valid got=%b exp=0", bus.ex_valid);
    end
    tests++;
    if (bus.alu_control !== 3'b000) begin
      fails++; $display("FAIL rst_alu_ctl got=%b exp=000", bus.alu_control);
    end
    tests++;
    if (bus.ex_reg_write !== 1'b0) begin
      fails++; $display("FAIL rst_reg_write got=%b exp=0", bus.ex_reg_write);
    end
    tests++;
    if (bus.ex_pc !== 32'h0 || bus.src_a !== 32'h0) begin
      fails++; $display("FAIL rst_data got pc=%h a=%h exp=0", bus.ex_pc, bus.src_a);
    end
    rst_n = 1;
    tick();
    @(negedge clk);
    tests++;
    if (bus.ex_valid !== 1'b1 || bus.ex_rd !== 5'd3) begin
      fails++; $display("FAIL rel_capture got v=%b rd=%0d exp v=1 rd=3", bus.ex_valid, bus.ex_rd);
    end
    tests++;
    if (bus.alu_control !== 3'b011 || bus.ex_reg_write !== 1'b1) begin
      fails++; $display("FAIL rel_ctl got ctl=%b rw=%b exp 011/1", bus.alu_control, bus.ex_reg_write);
    end
    tests++;
    if (bus.src_a !== 32'd9 || bus.ex_pc !== 32'h100) begin
      fails++; $display("FAIL rel_data got a=%h pc=%h exp 9/100", bus.src_a, bus.ex_pc);
    end
  endtask

  task automatic test_pass_through();
    clear_in();
    bus.id_valid = 1; bus.id_rs1_data = 5; bus.id_imm = 7;
    bus.id_alu_src = 1; bus.id_alu_control = 3'b000;
    bus.id_rs1 = 1; bus.id_rs2 = 2; bus.id_rd = 8;
    tick();
    @(negedge clk);
    tests++;
    if (bus.src_a !== 32'd5 || bus.src_b !== 32'd7) begin
      fails++; $display("FAIL pt_imm got a=%h b=%h exp 5/7", bus.src_a, bus.src_b);
    end
    tests++;
    if (bus.alu_control !== 3'b000) begin
      fails++; $display("FAIL pt_ctl got=%b exp=000", bus.alu_control);
    end
    bus.id_alu_control = 3'b001; bus.id_alu_src = 0;
    bus.id_rs1_data = 32'h44; bus.id_rs2_data = 32'h33;
    tick();
    @(negedge clk);
    tests++;
    if (bus.src_a !== 32'h44 || bus.src_b !== 32'h33) begin
      fails++; $display("FAIL pt_reg got a=%h b=%h exp 44/33", bus.src_a, bus.src_b);
    end
    tests++;
    if (bus.ex_store_data !== 32'h33 || bus.alu_control !== 3'b001) begin
      fails++; $display("FAIL pt_sd got sd=%h ctl=%b exp 33/001", bus.ex_store_data, bus.alu_control);
    end
  endtask

  task automatic test_forwarding();
    logic [31:0] e;
    clear_in();
    bus.id_valid = 1; bus.id_rs1 = 3; bus.id_rs1_data = 32'h55;
    bus.id_rs2 = 6; bus.id_rs2_data = 32'h66;
    tick();
    bus.id_valid = 0; bus.ex_hold = 1;
    bus.mem_rd = 3; bus.mem_reg_write = 1; bus.mem_result = 32'h10;
    bus.wb_rd = 3; bus.wb_reg_write = 1; bus.wb_result = 32'h20;
    @(negedge clk);
    e = FWD ? 32'h10 : 32'h55;
    tests++;
    if (bus.src_a !== e) begin
      fails++; $display("FAIL fwd_mem_prio got=%h exp=%h", bus.src_a, e);
    end
    bus.mem_reg_write = 0;
    #2;
    e = FWD ? 32'h20 : 32'h55;
    tests++;
    if (bus.src_a !== e) begin
      fails++; $display("FAIL fwd_wb got=%h exp=%h", bus.src_a, e);
    end
    bus.mem_rd = 6; bus.mem_reg_write = 1;
    #2;
    e = FWD ? 32'h10 : 32'h66;
    tests++;
    if (bus.ex_store_data !== e || bus.src_b !== e) begin
      fails++; $display("FAIL fwd_rs2 got sd=%h b=%h exp=%h", bus.ex_store_data, bus.src_b, e);
    end
    bus.mem_rd = 0; bus.wb_rd = 0;
    #2;
    tests++;
    if (bus.src_a !== 32'h55) begin
      fails++; $display("FAIL fwd_rd0 got=%h exp=55", bus.src_a);
    end
    bus.ex_hold = 0; bus.id_valid = 1;
    bus.id_rs1 = 0; bus.id_rs1_data = 32'h77;
    tick();
    @(negedge clk);
    tests++;
    if (bus.src_a !== 32'h77) begin
      fails++; $display("FAIL fwd_rs1_x0 got=%h exp=77", bus.src_a);
    end
  endtask

  task automatic test_load_use();
    logic        es, ev;
    logic [31:0] esd;
    clear_in();
    bus.id_valid = 1; bus.id_rd = 5; bus.id_reg_write = 1;
    bus.id_mem_read = 1; bus.id_rs1 = 1;
    tick();
    bus.id_mem_read = 0; bus.id_rd = 7; bus.id_rs1 = 2;
    bus.id_rs2 = 5; bus.id_use_rs2 = 1;
    bus.id_alu_control = 3'b010;
    for (int c = 0; c < 5; c++) begin
      bus.mem_rd = (c == 1) ? 5'd5 : 5'd0;
      bus.mem_reg_write = (c == 1);
      bus.wb_rd = (c == 2) ? 5'd5 : 5'd0;
      bus.wb_reg_write = (c == 2);
      bus.wb_result = 32'hBEEF;
      bus.id_rs2_data = (c >= 2) ? 32'hBEEF : 32'hAA;
      @(negedge clk);
      es  = FWD ? (c == 0) : (c <= 2);
      ev  = (c == 0) || (c >= 2 && (FWD || c >= 4));
      esd = (c >= 2 && (FWD || c >= 4)) ? 32'hBEEF : 32'h0;
      tests++;
      if (bus.stall_req !== es) begin
        fails++; $display("FAIL lu_stall c=%0d got=%b exp=%b", c, bus.stall_req, es);
      end
      tests++;
      if (bus.ex_valid !== ev) begin
        fails++; $display("FAIL lu_valid c=%0d got=%b exp=%b", c, bus.ex_valid, ev);
      end
      tests++;
      if (bus.ex_store_data !== esd) begin
        fails++; $display("FAIL lu_sd c=%0d got=%h exp=%h", c, bus.ex_store_data, esd);
      end
      tick();
    end
  endtask

  task automatic test_flush_hold();
    clear_in();
    bus.id_valid = 1; bus.id_rd = 9; bus.id_alu_control = 3'b011;
    bus.id_rs1_data = 32'h12; bus.id_imm = 32'h34; bus.id_alu_src = 1;
    bus.id_reg_write = 1; bus.id_pc = 32'h200;
    tick();
    bus.ex_hold = 1; bus.id_rd = 10;
    bus.id_rs1_data = 32'h99; bus.id_pc = 32'h300;
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      tests++;
      if (bus.src_a !== 32'h12 || bus.src_b !== 32'h34 ||
          bus.ex_rd !== 5'd9 || bus.ex_pc !== 32'h200 ||
          bus.alu_control !== 3'b011) begin
        fails++; $display("FAIL hold_keep i=%0d got a=%h b=%h rd=%0d pc=%h exp 12/34/9/200", i, bus.src_a, bus.src_b, bus.ex_rd, bus.ex_pc);
      end
      tests++;
      if (bus.stall_req !== 1'b1) begin
        fails++; $display("FAIL hold_stall i=%0d got=%b exp=1", i, bus.stall_req);
      end
    end
    bus.ex_flush = 1;
    tick();
    @(negedge clk);
    tests++;
    if (bus.ex_valid !== 1'b0 || bus.ex_reg_write !== 1'b0) begin
      fails++; $display("FAIL flush_over_hold got v=%b rw=%b exp 0/0", bus.ex_valid, bus.ex_reg_write);
    end
    clear_in();
  endtask

  task automatic test_raw_stall();
    logic        es, ev;
    logic [31:0] ea;
    clear_in();
    bus.id_valid = 1; bus.id_rd = 4; bus.id_reg_write = 1;
    tick();
    bus.id_rd = 6; bus.id_rs1 = 4; bus.id_use_rs1 = 1;
    for (int c = 0; c < 5; c++) begin
      bus.mem_rd = (c == 1) ? 5'd4 : 5'd0;
      bus.mem_reg_write = (c == 1);
      bus.mem_result = 32'h4444;
      bus.wb_rd = (c == 2) ? 5'd4 : 5'd0;
      bus.wb_reg_write = (c == 2);
      bus.wb_result = 32'h4444;
      bus.id_rs1_data = (c >= 2) ? 32'h4444 : 32'h1111;
      @(negedge clk);
      es = !FWD && c <= 2;
      ev = (c == 0) || FWD || c >= 4;
      ea = (c != 0 && (FWD || c >= 4)) ? 32'h4444 : 32'h0;
      tests++;
      if (bus.stall_req !== es) begin
        fails++; $display("FAIL raw_stall c=%0d got=%b exp=%b", c, bus.stall_req, es);
      end
      tests++;
      if (bus.ex_valid !== ev || bus.src_a !== ea) begin
        fails++; $display("FAIL raw_ex c=%0d got v=%b a=%h exp v=%b a=%h", c, bus.ex_valid, bus.src_a, ev, ea);
      end
      tick();
    end
  endtask

  task automatic test_random();
    bit          bub;
    logic [31:0] ea, eb, esd;
    logic [2:0]  ectl;
    rst_n = 0;
    clear_in();
    tick();
    rst_n = 1;
    m = empty_rec();
    for (int cyc = 0; cyc < 600; cyc++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      bus.id_valid = ($urandom_range(0, 3) != 0);
      bus.id_pc = $urandom; bus.id_imm = $urandom;
      bus.id_rs1_data = $urandom; bus.id_rs2_data = $urandom;
      bus.id_rs1 = 5'($urandom_range(0, 5));
      bus.id_rs2 = 5'($urandom_range(0, 5));
      bus.id_rd = 5'($urandom_range(0, 5));
      bus.id_use_rs1 = 1'($urandom); bus.id_use_rs2 = 1'($urandom);
      bus.id_alu_src = 1'($urandom); bus.id_alu_control = 3'($urandom);
      bus.id_reg_write = 1'($urandom); bus.id_mem_read = 1'($urandom);
      bus.id_mem_write = 1'($urandom);
      bus.ex_hold = ($urandom_range(0, 7) == 0);
      bus.ex_flush = ($urandom_range(0, 9) == 0);
      bus.mem_rd = 5'($urandom_range(0, 5));
      bus.mem_reg_write = 1'($urandom); bus.mem_result = $urandom;
      bus.wb_rd = 5'($urandom_range(0, 5));
      bus.wb_reg_write = 1'($urandom); bus.wb_result = $urandom;
      @(negedge clk);
      bub  = model_bubble();
      ea   = model_opnd(m.rs1, m.a);
      esd  = model_opnd(m.rs2, m.b);
      eb   = m.isrc ? m.imm : esd;
      ectl = m.v ? {m.rw, m.mr, m.mw} : 3'b000;
      tests++;
      if (bus.stall_req !== (bub || bus.ex_hold)) begin
        fails++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, bus.stall_req, bub || bus.ex_hold);
      end
      tests++;
      if (bus.ex_valid !== m.v || bus.ex_pc !== m.pc) begin
        fails++; $display("FAIL rnd_valid_pc cyc=%0d got %b/%h exp %b/%h", cyc, bus.ex_valid, bus.ex_pc, m.v, m.pc);
      end
      tests++;
      if (bus.src_a !== ea) begin
        fails++; $display("FAIL rnd_src_a cyc=%0d got=%h exp=%h", cyc, bus.src_a, ea);
      end
      tests++;
      if (bus.src_b !== eb) begin
        fails++; $display("FAIL rnd_src_b cyc=%0d got=%h exp=%h", cyc, bus.src_b, eb);
      end
      tests++;
      if (bus.ex_store_data !== esd) begin
        fails++; $display("FAIL rnd_store cyc=%0d got=%h exp=%h", cyc, bus.ex_store_data, esd);
      end
      tests++;
      if (bus.alu_control !== m.ctl || bus.ex_rd !== m.rd) begin
        fails++; $display("FAIL rnd_ctl_rd cyc=%0d got %b/%0d exp %b/%0d", cyc, bus.alu_control, bus.ex_rd, m.ctl, m.rd);
      end
      tests++;
      if ({bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write} !== ectl) begin
        fails++; $display("FAIL rnd_ctrl_bits cyc=%0d got=%b exp=%b", cyc, {bus.ex_reg_write, bus.ex_mem_read, bus.ex_mem_write}, ectl);
      end
      if (!rst_n || bus.ex_flush) begin
        m = empty_rec();
      end else if (bus.ex_hold) begin
        m = m;
      end else if (bub) begin
        m = empty_rec();
      end else begin
        m.v = bus.id_valid; m.pc = bus.id_pc;
        m.a = bus.id_rs1_data; m.b = bus.id_rs2_data; m.imm = bus.id_imm;
        m.rs1 = bus.id_rs1; m.rs2 = bus.id_rs2; m.rd = bus.id_rd;
        m.isrc = bus.id_alu_src; m.ctl = bus.id_alu_control;
        m.rw = bus.id_valid && bus.id_reg_write;
        m.mr = bus.id_valid && bus.id_mem_read;
        m.mw = bus.id_valid && bus.id_mem_write;
      end
      tick();
    end
    rst_n = 1;
  endtask

  initial begin
    clear_in();
    test_reset();
    test_pass_through();
    test_forwarding();
    test_load_use();
    test_flush_hold();
    test_raw_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
